// File: rtl/seven_segment_scan_decoder.sv
// Recovers the 4-digit number shown on a scanned, multiplexed 7-segment display.
// Optional macro SEG_BLANK_DIGIT_EN: an all-off digit decodes as 0 without flagging an error.
module seven_segment_scan_decoder #(
    parameter int STABLE_CYCLES = 1024
) (
    input  logic        clock_100Mhz,
    input  logic        reset,
    input  logic [3:0]  Anode_Activate,
    input  logic [6:0]  LED_out,
    output logic [15:0] number_out,
    output logic [15:0] digits_bcd,
    output logic        number_valid,
    output logic        decode_error,
    output logic [1:0]  dbg_state
);

    // number_valid is a one-cycle strobe with no back-pressure: the consumer must
    // take number_out/digits_bcd/decode_error while it is high (they also hold after).

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_CONVERT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [15:0] STABLE_MAX = 16'(STABLE_CYCLES);
    localparam logic [15:0] SAMPLE_AT  = 16'(STABLE_CYCLES - 2);

    // Returns {error, digit[3:0]}.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] r;
        r = 5'b1_0000;
        case (seg)
            7'b0000001: r = 5'd0;
            7'b1001111: r = 5'd1;
            7'b0010010: r = 5'd2;
            7'b0000110: r = 5'd3;
            7'b1001100: r = 5'd4;
            7'b0100100: r = 5'd5;
            7'b0100000: r = 5'd6;
            7'b0001111: r = 5'd7;
            7'b0000000: r = 5'd8;
            7'b0000100: r = 5'd9;
`ifdef SEG_BLANK_DIGIT_EN
            7'b1111111: r = 5'd0;
`endif
            default:    r = 5'b1_0000;
        endcase
        return r;
    endfunction

    // Returns {legal, index[1:0]}; index 0 is the thousands digit.
    function automatic logic [2:0] anode_index(input logic [3:0] an);
        logic [2:0] r;
        case (an)
            4'b0111: r = 3'b100;
            4'b1011: r = 3'b101;
            4'b1101: r = 3'b110;
            4'b1110: r = 3'b111;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    logic [3:0]       anode_q, anode_d, anode_prev_q, anode_prev_d;
    logic [6:0]       led_q, led_d, led_prev_q, led_prev_d;
    logic [15:0]      stab_cnt_q, stab_cnt_d;
    state_t           state_q, state_d;
    logic [1:0]       expect_q, expect_d;
    logic [3:0][3:0]  digits_q, digits_d;
    logic             frame_err_q, frame_err_d;
    logic [1:0]       conv_idx_q, conv_idx_d;
    logic [13:0]      acc_q, acc_d;
    logic [15:0]      number_q, number_d;
    logic [15:0]      bcd_q, bcd_d;
    logic             dec_err_q, dec_err_d;

    logic             inputs_stable;
    logic             anode_legal;
    logic [1:0]       sample_idx;
    logic             seg_err;
    logic [3:0]       seg_digit;
    logic             sample_fire;
    logic [13:0]      acc_next;

    // Input capture and stability tracking
    always_comb begin
        anode_d      = Anode_Activate;
        led_d        = LED_out;
        anode_prev_d = anode_q;
        led_prev_d   = led_q;

        inputs_stable = (anode_q == anode_prev_q) && (led_q == led_prev_q);
        if (!inputs_stable) begin
            stab_cnt_d = 16'd0;
        end else if (stab_cnt_q == STABLE_MAX) begin
            stab_cnt_d = stab_cnt_q;
        end else begin
            stab_cnt_d = stab_cnt_q + 16'd1;
        end

        {anode_legal, sample_idx} = anode_index(anode_q);
        {seg_err, seg_digit}      = decode_seg(led_q);

        // Fires in the one cycle of each dwell where the counter steps to STABLE_CYCLES-1.
        sample_fire = inputs_stable && (stab_cnt_q == SAMPLE_AT) && anode_legal;
    end

    // Frame assembly and conversion FSM
    always_comb begin
        state_d     = state_q;
        expect_d    = expect_q;
        digits_d    = digits_q;
        frame_err_d = frame_err_q;
        conv_idx_d  = conv_idx_q;
        acc_d       = acc_q;
        number_d    = number_q;
        bcd_d       = bcd_q;
        dec_err_d   = dec_err_q;
        acc_next    = acc_q * 14'd10 + {10'd0, digits_q[conv_idx_q]};

        case (state_q)
            ST_IDLE: begin
                if (sample_fire && (sample_idx == 2'd0)) begin
                    digits_d[0] = seg_digit;
                    frame_err_d = seg_err;
                    expect_d    = 2'd1;
                    state_d     = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (sample_fire) begin
                    if (sample_idx == expect_q) begin
                        digits_d[sample_idx] = seg_digit;
                        frame_err_d          = frame_err_q | seg_err;
                        expect_d             = expect_q + 2'd1;
                        if (sample_idx == 2'd3) begin
                            state_d    = ST_CONVERT;
                            conv_idx_d = 2'd0;
                            acc_d      = 14'd0;
                        end
                    end else if (sample_idx == 2'd0) begin
                        // A fresh thousands digit restarts the frame rather than dropping it.
                        digits_d[0] = seg_digit;
                        frame_err_d = seg_err;
                        expect_d    = 2'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_CONVERT: begin
                acc_d      = acc_next;
                conv_idx_d = conv_idx_q + 2'd1;
                if (conv_idx_q == 2'd3) begin
                    state_d   = ST_DONE;
                    number_d  = {2'b00, acc_next};
                    bcd_d     = {digits_q[0], digits_q[1], digits_q[2], digits_q[3]};
                    dec_err_d = frame_err_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            anode_q      <= 4'b1111;
            led_q        <= 7'b1111111;
            anode_prev_q <= 4'b1111;
            led_prev_q   <= 7'b1111111;
            stab_cnt_q   <= 16'd0;
            state_q      <= ST_IDLE;
            expect_q     <= 2'd0;
            digits_q     <= '0;
            frame_err_q  <= 1'b0;
            conv_idx_q   <= 2'd0;
            acc_q        <= 14'd0;
            number_q     <= 16'd0;
            bcd_q        <= 16'd0;
            dec_err_q    <= 1'b0;
        end else begin
            anode_q      <= anode_d;
            led_q        <= led_d;
            anode_prev_q <= anode_prev_d;
            led_prev_q   <= led_prev_d;
            stab_cnt_q   <= stab_cnt_d;
            state_q      <= state_d;
            expect_q     <= expect_d;
            digits_q     <= digits_d;
            frame_err_q  <= frame_err_d;
            conv_idx_q   <= conv_idx_d;
            acc_q        <= acc_d;
            number_q     <= number_d;
            bcd_q        <= bcd_d;
            dec_err_q    <= dec_err_d;
        end
    end

    assign number_out   = number_q;
    assign digits_bcd   = bcd_q;
    assign decode_error = dec_err_q;
    assign number_valid = (state_q == ST_DONE);
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Bench for seven_segment_scan_decoder: table-driven frames plus hand-written
// abort/reset sequences, checked by a scoreboard queue of expected results.
module tb_seven_segment_scan_decoder;

    localparam int S    = 16;
    localparam int HOLD = 32;
    localparam int W    = 65;  // {due_cycle[31:0], number[15:0], bcd[15:0], err}

`ifdef SEG_BLANK_DIGIT_EN
    localparam logic BLANK_ERR = 1'b0;
`else
    localparam logic BLANK_ERR = 1'b1;
`endif

    typedef struct packed {
        logic [3:0][6:0] seg;
        logic [15:0]     num;
        logic [15:0]     bcd;
        logic            err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  Anode_Activate;
    logic [6:0]  LED_out;
    logic [15:0] number_out;
    logic [15:0] digits_bcd;
    logic        number_valid;
    logic        decode_error;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] e;
    logic [15:0]  last_num;
    logic [15:0]  last_bcd;
    logic         last_err;

    logic [6:0] seg_lut[10];
    logic [3:0] an_lut[4];
    vec_t       vecs[7];

    seven_segment_scan_decoder #(.STABLE_CYCLES(S)) dut (
        .clock_100Mhz  (clk),
        .reset         (reset),
        .Anode_Activate(Anode_Activate),
        .LED_out       (LED_out),
        .number_out    (number_out),
        .digits_bcd    (digits_bcd),
        .number_valid  (number_valid),
        .decode_error  (decode_error),
        .dbg_state     (dbg_state)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: pop on every valid pulse
    always @(negedge clk) begin
        if (!reset && number_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid actual=%0h required=no_pulse", number_out);
            end else begin
                e = exp_q.pop_front();
                check("valid_cycle",  cyc,          e[64:33]);
                check("number_out",   number_out,   {16'd0, e[32:17]});
                check("digits_bcd",   digits_bcd,   {16'd0, e[16:1]});
                check("decode_error", decode_error, {31'd0, e[0]});
                last_num = e[32:17];
                last_bcd = e[16:1];
                last_err = e[0];
            end
        end
    end

    // Drivers
    task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n,
                        input logic push, input logic [32:0] res);
        @(negedge clk);
        Anode_Activate = an;
        LED_out        = seg;
        if (push) exp_q.push_back({32'(cyc + S + 5), res});
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [3:0][6:0] seg, input logic expect_valid,
                              input logic [15:0] num, input logic [15:0] bcd, input logic err);
        for (int i = 0; i < 4; i++)
            hold(an_lut[i], seg[i], HOLD, expect_valid && (i == 3), {num, bcd, err});
    endtask

    task automatic check_held(input string tag);
        repeat (30) @(negedge clk);
        check({tag, "_num"},   number_out,   {16'd0, last_num});
        check({tag, "_bcd"},   digits_bcd,   {16'd0, last_bcd});
        check({tag, "_err"},   decode_error, {31'd0, last_err});
        check({tag, "_state"}, dbg_state,    32'd0);
    endtask

    function automatic vec_t mk(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c,
                                input logic [6:0] d, input logic [15:0] n, input logic [15:0] bcd,
                                input logic err);
        vec_t v;
        v.seg[0] = a;
        v.seg[1] = b;
        v.seg[2] = c;
        v.seg[3] = d;
        v.num    = n;
        v.bcd    = bcd;
        v.err    = err;
        return v;
    endfunction

    initial begin
        int d0, d1, d2, d3;
        logic [3:0][6:0] sg;

        seg_lut = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
        an_lut  = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

        vecs[0] = mk(seg_lut[1], seg_lut[2], seg_lut[3], seg_lut[4], 16'h04D2, 16'h1234, 1'b0);
        vecs[1] = mk(seg_lut[9], seg_lut[9], seg_lut[9], seg_lut[9], 16'h270F, 16'h9999, 1'b0);
        vecs[2] = mk(seg_lut[5], seg_lut[7], 7'b1111110, seg_lut[1], 16'h1645, 16'h5701, 1'b1);
        vecs[3] = mk(seg_lut[0], seg_lut[0], seg_lut[4], seg_lut[2], 16'h002A, 16'h0042, 1'b0);
        vecs[4] = mk(7'b1111111, seg_lut[0], seg_lut[4], seg_lut[2], 16'h002A, 16'h0042, BLANK_ERR);
        vecs[5] = mk(seg_lut[6], seg_lut[7], seg_lut[8], seg_lut[0], 16'h1A7C, 16'h6780, 1'b0);
        vecs[6] = mk(seg_lut[0], seg_lut[0], seg_lut[0], seg_lut[0], 16'h0000, 16'h0000, 1'b0);

        // Reset
        reset          = 1'b1;
        Anode_Activate = 4'b1111;
        LED_out        = 7'b1111111;
        last_num       = 16'd0;
        last_bcd       = 16'd0;
        last_err       = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_number", number_out,   32'd0);
        check("rst_bcd",    digits_bcd,   32'd0);
        check("rst_valid",  number_valid, 32'd0);
        check("rst_err",    decode_error, 32'd0);
        check("rst_state",  dbg_state,    32'd0);

        // Table-driven frames
        for (int k = 0; k < 7; k++)
            send_frame(vecs[k].seg, 1'b1, vecs[k].num, vecs[k].bcd, vecs[k].err);

        // Random legal frames
        for (int k = 0; k < 4; k++) begin
            d0 = $urandom_range(0, 9);
            d1 = $urandom_range(0, 9);
            d2 = $urandom_range(0, 9);
            d3 = $urandom_range(0, 9);
            sg[0] = seg_lut[d0];
            sg[1] = seg_lut[d1];
            sg[2] = seg_lut[d2];
            sg[3] = seg_lut[d3];
            send_frame(sg, 1'b1, 16'(d0 * 1000 + d1 * 100 + d2 * 10 + d3),
                       {4'(d0), 4'(d1), 4'(d2), 4'(d3)}, 1'b0);
        end

        // Short dwell on digit 1, then digit 2 out of order: frame dropped
        hold(an_lut[0], seg_lut[3], HOLD, 1'b0, '0);
        hold(an_lut[1], seg_lut[5], 10,   1'b0, '0);
        hold(an_lut[2], seg_lut[6], HOLD, 1'b0, '0);
        hold(an_lut[3], seg_lut[7], HOLD, 1'b0, '0);
        check_held("abort_short");

        // Digit 0 then digit 2: abort to idle, trailing digit 3 ignored
        hold(an_lut[0], seg_lut[1], HOLD, 1'b0, '0);
        hold(an_lut[2], seg_lut[1], HOLD, 1'b0, '0);
        hold(an_lut[3], seg_lut[1], HOLD, 1'b0, '0);
        check_held("abort_skip");

        // Repeated digit 0 restarts the frame
        hold(an_lut[0], seg_lut[2], HOLD, 1'b0, '0);
        hold(an_lut[1], seg_lut[3], HOLD, 1'b0, '0);
        hold(an_lut[0], seg_lut[4], HOLD, 1'b0, '0);
        hold(an_lut[1], seg_lut[5], HOLD, 1'b0, '0);
        hold(an_lut[2], seg_lut[6], HOLD, 1'b0, '0);
        hold(an_lut[3], seg_lut[7], HOLD, 1'b1, {16'h11D7, 16'h4567, 1'b0});

        // Illegal anode pattern never samples
        hold(4'b0011, seg_lut[8], HOLD, 1'b0, '0);
        check_held("bad_anode");

        // Reset mid-frame
        hold(an_lut[0], seg_lut[8], HOLD, 1'b0, '0);
        hold(an_lut[1], seg_lut[0], HOLD, 1'b0, '0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_number", number_out,   32'd0);
        check("midrst_bcd",    digits_bcd,   32'd0);
        check("midrst_err",    decode_error, 32'd0);
        check("midrst_state",  dbg_state,    32'd0);
        last_num = 16'd0;
        last_bcd = 16'd0;
        last_err = 1'b0;
        hold(an_lut[2], seg_lut[0], HOLD, 1'b0, '0);
        hold(an_lut[3], seg_lut[6], HOLD, 1'b0, '0);
        check_held("postrst_partial");
        sg[0] = seg_lut[8];
        sg[1] = seg_lut[0];
        sg[2] = seg_lut[0];
        sg[3] = seg_lut[6];
        send_frame(sg, 1'b1, 16'h1F46, 16'h8006, 1'b0);

        // Drain scoreboard with a bounded wait
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_valid actual=%0d_pending required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seven_segment_scan_decoder.md
SEVEN_SEGMENT_SCAN_DECODER -- requirements
Module: seven_segment_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 1024: consecutive unchanged input cycles required before a digit is sampled; legal range 8..65535.
REQ-002 SHALL have port clock_100Mhz, input, 1 bit: sole clock; all logic on rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port Anode_Activate, input, 4 bits: active-low digit select; 0111 selects digit 0 (thousands), 1011 digit 1, 1101 digit 2, 1110 digit 3.
REQ-005 SHALL have port LED_out, input, 7 bits: active-low cathodes; bit6 = segment a through bit0 = segment g.
REQ-006 SHALL have port number_out, output, 16 bits: binary value of the last completed frame, 0..9999.
REQ-007 SHALL have port digits_bcd, output, 16 bits: last completed frame as BCD {d0,d1,d2,d3}, d0 in [15:12].
REQ-008 SHALL have port number_valid, output, 1 bit: one-cycle pulse when number_out/digits_bcd update.
REQ-009 SHALL have port decode_error, output, 1 bit: set with number_valid if any digit of that frame had an unrecognised pattern; held until next number_valid.

Function
REQ-010 SHALL register Anode_Activate and LED_out once; all subsequent logic uses registered copies.
REQ-011 SHALL keep a stability counter: cleared when either registered input differs from previous cycle, else incremented, saturating at STABLE_CYCLES.
REQ-012 SHALL sample exactly once per dwell: in the cycle the counter reaches STABLE_CYCLES-1, only if anode is one of the four legal patterns; other anode patterns never sample.
REQ-013 SHALL decode cathodes: 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9; any other pattern yields digit 0 and flags frame error.
REQ-014 SHALL implement FSM IDLE, COLLECT, CONVERT, DONE.
REQ-015 IDLE: a digit-0 sample stores d0, clears frame error, goes to COLLECT expecting digit 1; other samples ignored.
REQ-016 COLLECT: sample of expected index stores it and advances expectation; digit-3 sample goes to CONVERT.
REQ-017 COLLECT: out-of-order sample aborts frame; if it is digit 0 it starts a new frame (stays COLLECT, expects 1), else goes IDLE; outputs unchanged on abort.
REQ-018 CONVERT SHALL take exactly 4 cycles computing acc = acc*10 + d(i) for i=0..3, acc width 14 bits min, zero-extended to 16.
REQ-019 DONE lasts 1 cycle: number_out, digits_bcd, decode_error updated and number_valid high; next cycle IDLE.
REQ-020 Latency: digit-3 sample in cycle T → number_valid high in cycle T+5.
REQ-021 Samples occurring in CONVERT or DONE SHALL be ignored (impossible for legal STABLE_CYCLES, but defined).
REQ-022 number_out and digits_bcd SHALL hold between frames.

Reset
REQ-023 On reset: number_out=0, digits_bcd=0, number_valid=0, decode_error=0, FSM=IDLE, counter=0, input registers=4'b1111/7'b1111111.
REQ-024 Reset mid-frame SHALL discard partial digits; first post-reset frame must start at digit 0.

Configuration
REQ-025 Macro SEG_BLANK_DIGIT_EN: when defined, cathode 1111111 (all off) decodes as digit 0 without setting frame error; when undefined, 1111111 is an unrecognised pattern per REQ-013.

Verification
REQ-026 STABLE_CYCLES=16, digits 1,2,3,4 each held 32 cycles in order → single number_valid, number_out=1234 (0x04D2), digits_bcd=0x1234, decode_error=0, valid 5 cycles after digit-3 sample.
REQ-027 Frame 9,9,9,9 → number_out=9999 (0x270F), digits_bcd=0x9999.
REQ-028 Frame 5,7,{1111110},1 → number_out=5701, digits_bcd=0x5701, decode_error=1; next clean frame 0,0,4,2 → 42, decode_error=0.
REQ-029 Digit 1 held only 10 cycles then digit 2 → frame aborted, no number_valid; anode 0111 then 1101 → abort to IDLE; outputs unchanged.
REQ-030 Reset asserted after digits 0,1 sampled → outputs 0; subsequent digits 2,3 alone give no valid; following full frame 8,0,0,6 → 8006.
REQ-031 Blank digit 0 (1111111) then 0,4,2: with SEG_BLANK_DIGIT_EN → 42, decode_error=0; without → 42, decode_error=1.
